// File: rtl/btn_conditioner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner_pkg                                          |
// | Description : Shared FSM state type, default timing constants and a small  |
// |               width helper for the push-button conditioner.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package btn_conditioner_pkg;

  // Per-channel repeat FSM state
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DELAY  = 2'd1;
  localparam state_t ST_REPEAT = 2'd2;

  // Default timing for the clock/alarm front panel
  localparam int DEF_N_BTN        = 2;
  localparam int DEF_DEBOUNCE_CYC = 4;
  localparam int DEF_REPEAT_DELAY = 16;
  localparam int DEF_REPEAT_RATE  = 8;
  localparam int DEF_REPEAT_EN    = 1;

  // Larger of two integers, used to size the shared repeat counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_conditioner_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_channel                                                  |
// | Description : One button channel: 2-flop synchroniser, debouncer, and      |
// |               press / auto-repeat pulse FSM.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  input  logic en,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

  localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [RPT_W-1:0] c_rpt_delay = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] c_rpt_rate  = RPT_W'(REPEAT_RATE - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  state_t           state_q, state_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             pulse_q, pulse_d;
  logic             w_rise;

  // Synchroniser: straight two-flop chain, nothing in between
  always_comb begin
    s1_d = btn_raw;
    s2_d = s1_q;
  end

  // Debounce: accept a new level only after DEBOUNCE_CYC consecutive
  // disagreeing samples; any agreeing sample restarts the count
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (s2_q != level_q) begin
      if (db_cnt_q == c_db_last) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  // Rising edge taken from the next-state level so the press pulse is
  // registered in the same edge as the level itself
  assign w_rise = level_d & ~level_q;

  // Pulse FSM: press pulse, then initial delay, then steady repeat; a
  // falling level or dropped enable cancels everything in the same cycle
  always_comb begin
    state_d   = state_q;
    rpt_cnt_d = rpt_cnt_q;
    pulse_d   = 1'b0;
    if (!level_d || !en) begin
      state_d   = ST_IDLE;
      rpt_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_rise) begin
            pulse_d = 1'b1;
            if (REPEAT_EN != 0) begin
              state_d   = ST_DELAY;
              rpt_cnt_d = c_rpt_delay;
            end
          end
        end
        ST_DELAY: begin
          if (rpt_cnt_q == '0) begin
            pulse_d   = 1'b1;
            state_d   = ST_REPEAT;
            rpt_cnt_d = c_rpt_rate;
          end else begin
            rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (rpt_cnt_q == '0) begin
            pulse_d   = 1'b1;
            rpt_cnt_d = c_rpt_rate;
          end else begin
            rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end
  end

  // State registers, all cleared immediately by the panel reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      db_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      rpt_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      rpt_cnt_q <= rpt_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_conditioner                                              |
// | Description : Front-panel button conditioner; one independent channel per  |
// |               button producing a debounced level and increment pulses.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN        = DEF_N_BTN,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE,
  parameter int REPEAT_EN    = DEF_REPEAT_EN
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  // One fully independent channel per button; no arbitration here
  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
      btn_channel #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE),
        .REPEAT_EN    (REPEAT_EN)
      ) u_chan (
        .clk       (clk),
        .clr       (clr),
        .btn_raw   (btn_raw[i]),
        .en        (en),
        .btn_level (btn_level[i]),
        .btn_pulse (btn_pulse[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire
